// File: rtl/ballot_pkg.sv
// Shared types for the ballot scheduler: poll phase and transaction state encodings,
// plus the one-hot check applied to each booth's candidate choice.
package ballot_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'b00,
        PH_OPEN   = 2'b01,
        PH_CLOSED = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } txn_state_t;

    // Exactly one bit set; zero and multi-hot both count as invalid.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/ballot_scheduler_if.sv
// Booth, tally and poll-control signals of the ballot scheduler.
// slave = scheduler side, master = booth/datapath/controller side.
interface ballot_scheduler_if #(
    parameter int NUM_BOOTHS = 4,
    parameter int NUM_CAND   = 4,
    parameter int TOT_W      = 12
);
    logic                           open_poll;
    logic                           close_poll;
    logic                           clear_poll;
    logic [NUM_BOOTHS-1:0]          booth_req;
    logic [NUM_BOOTHS*NUM_CAND-1:0] booth_choice;
    logic [NUM_BOOTHS-1:0]          booth_ack;
    logic [NUM_BOOTHS-1:0]          booth_nack;
    logic                           tally_valid;
    logic [NUM_CAND-1:0]            tally_sel;
    logic                           tally_ready;
    logic                           tally_clr;
    logic [1:0]                     phase;
    logic [TOT_W-1:0]               votes_cast;
    logic                           err;
    logic                           busy;

    modport slave (
        input  open_poll, close_poll, clear_poll, booth_req, booth_choice, tally_ready,
        output booth_ack, booth_nack, tally_valid, tally_sel, tally_clr, phase,
               votes_cast, err, busy
    );

    modport master (
        output open_poll, close_poll, clear_poll, booth_req, booth_choice, tally_ready,
        input  booth_ack, booth_nack, tally_valid, tally_sel, tally_clr, phase,
               votes_cast, err, busy
    );
endinterface

// File: rtl/ballot_scheduler_rr_arbiter.sv
// Round-robin pick: first eligible requester at or after pointer, wrapping upward.
// Purely combinational.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] pointer,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] idx;

    // Scan from the farthest candidate down so the nearest one to pointer wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(pointer) + k) % N);
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/ballot_scheduler.sv
// Poll-phase sequencer sharing one tally datapath between booths, round-robin.
// Grant to ack/nack in 3 cycles with tally_ready high; waits up to TIMEOUT cycles on tally_ready.
module ballot_scheduler
    import ballot_pkg::*;
#(
    parameter int NUM_BOOTHS = 4,
    parameter int NUM_CAND   = 4,
    parameter int TIMEOUT    = 255,
    parameter int TOT_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    ballot_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_BOOTHS);
    localparam int CW = $clog2(TIMEOUT + 1);

    phase_t                phase_q, phase_d;
    txn_state_t            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         gnt_idx_q, gnt_idx_d;
    logic [NUM_CAND-1:0]   choice_q, choice_d;
    logic                  ok_q, ok_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [TOT_W-1:0]      votes_q, votes_d;
    logic                  err_q, err_d;
    logic                  clr_q, clr_d;
    logic [NUM_BOOTHS-1:0] arm_q, arm_d;

    logic [NUM_BOOTHS-1:0] eligible;
    logic                  grant_valid;
    logic [IW-1:0]         grant_idx;
    logic [NUM_CAND-1:0]   choice_arr [NUM_BOOTHS];
    logic [NUM_BOOTHS-1:0] gnt_oh;

    for (genvar g = 0; g < NUM_BOOTHS; g++) begin : g_choice
        assign choice_arr[g] = bus.booth_choice[g*NUM_CAND +: NUM_CAND];
    end

    assign eligible = bus.booth_req & arm_q;

    rr_arbiter #(.N(NUM_BOOTHS), .IW(IW)) u_arb (
        .eligible    (eligible),
        .pointer     (ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        phase_d   = phase_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        choice_d  = choice_q;
        ok_d      = ok_q;
        wait_d    = wait_q;
        votes_d   = votes_q;
        err_d     = err_q;
        clr_d     = 1'b0;
        // A booth re-arms only after it has been seen idle, so a held request votes once.
        arm_d     = arm_q | ~bus.booth_req;

        unique case (phase_q)
            PH_IDLE: begin
                if (bus.clear_poll) begin
                    clr_d   = 1'b1;
                    votes_d = '0;
                    err_d   = 1'b0;
                end else if (bus.open_poll) begin
                    phase_d = PH_OPEN;
                end
            end
            PH_OPEN: begin
                if (bus.close_poll && state_q == ARB) phase_d = PH_CLOSED;
            end
            PH_CLOSED: begin
                if (bus.clear_poll) begin
                    phase_d = PH_IDLE;
                    clr_d   = 1'b1;
                    votes_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        unique case (state_q)
            ARB: begin
                // Closing wins over a grant in the same cycle.
                if (phase_q == PH_OPEN && !bus.close_poll && grant_valid) begin
                    gnt_idx_d = grant_idx;
                    choice_d  = choice_arr[grant_idx];
                    ptr_d     = (grant_idx == IW'(NUM_BOOTHS - 1)) ? '0 : grant_idx + 1'b1;
                    wait_d    = '0;
                    if (is_onehot(32'(choice_arr[grant_idx]))) begin
                        state_d = ISSUE;
                    end else begin
                        ok_d    = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (bus.tally_ready) begin
                    ok_d    = 1'b1;
                    votes_d = (&votes_q) ? votes_q : votes_q + 1'b1;
                    state_d = RESP;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                arm_d[gnt_idx_q] = 1'b0;
                state_d          = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            state_q   <= ARB;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            choice_q  <= '0;
            ok_q      <= 1'b0;
            wait_q    <= '0;
            votes_q   <= '0;
            err_q     <= 1'b0;
            clr_q     <= 1'b0;
            arm_q     <= '1;
        end else begin
            phase_q   <= phase_d;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            choice_q  <= choice_d;
            ok_q      <= ok_d;
            wait_q    <= wait_d;
            votes_q   <= votes_d;
            err_q     <= err_d;
            clr_q     <= clr_d;
            arm_q     <= arm_d;
        end
    end

    assign gnt_oh          = NUM_BOOTHS'(1) << gnt_idx_q;
    assign bus.tally_valid = (state_q == ISSUE);
    assign bus.tally_sel   = (state_q == ISSUE) ? choice_q : '0;
    assign bus.booth_ack   = (state_q == RESP && ok_q)  ? gnt_oh : '0;
    assign bus.booth_nack  = (state_q == RESP && !ok_q) ? gnt_oh : '0;
    assign bus.tally_clr   = clr_q;
    assign bus.phase       = phase_q;
    assign bus.votes_cast  = votes_q;
    assign bus.err         = err_q;
    assign bus.busy        = (state_q != ARB);

endmodule
